axil_reg_slave: RTL and testbench

AXI4-Lite responder holding a small bank of 32-bit control registers. It is the far end of our RBCP-to-AXI bridge: the bridge issues single-beat byte-lane writes and word reads, and this block accepts them, applies byte strobes, and drives the register outputs and write-strobe pulses into the user logic. It allows one outstanding transaction per direction, and the read and write directions operate independently.

---
 rtl/axil_reg_pkg.sv | 32 +++
 rtl/axil_strb_merge.sv | 29 ++
 rtl/axil_reg_slave.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_reg_pkg.sv
// -----------------------------------------------------------------------------
// axil_reg_pkg
// Shared definitions for the AXI4-Lite register responder:
//   - AXI response codes (RESP_OKAY, RESP_SLVERR)
//   - write-side and read-side FSM state typedefs
//   - default identification word returned at word index 0
//   - resp_code(): maps an error flag onto an AXI response code
// -----------------------------------------------------------------------------
package axil_reg_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  localparam logic [31:0] ID_DEFAULT  = 32'hD1C1_0001;
  localparam int          DATA_BYTES  = 4;

  typedef enum logic [1:0] {
    WR_ACCEPT = 2'd0,
    WR_COMMIT = 2'd1,
    WR_RESP   = 2'd2
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  function automatic logic [1:0] resp_code(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_strb_merge.sv
// -----------------------------------------------------------------------------
// axil_strb_merge
// Combinational byte-lane merge: each byte of the result comes from i_new
// where the matching strobe bit is set, otherwise from i_old.
// Ports:
//   i_old    [31:0]  current register contents
//   i_new    [31:0]  incoming write data
//   i_strb   [3:0]   byte-lane enables
//   o_merged [31:0]  merged word
// -----------------------------------------------------------------------------
module axil_strb_merge
  import axil_reg_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  logic [3:0]  i_strb,
  output logic [31:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (i_strb[b]) begin
        o_merged[8*b +: 8] = i_new[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// -----------------------------------------------------------------------------
// axil_reg_slave
// AXI4-Lite responder for a bank of NREG 32-bit read/write registers plus a
// read-only ID word at word index 0. One outstanding transaction per
// direction; read and write sides are independent.
//
// Handshake rule: a transfer happens on a rising clk edge where the channel's
// valid and ready are both high. Every ready/valid output here is a flop, so
// no input valid reaches a ready output combinationally.
//
// Address map (word index = addr[ADDR_W-1:2], addr[1:0] ignored):
//   0          ID word (ID_VALUE), writes ignored
//   1..NREG    register index-1
//   > NREG     out of range: reads return 0, writes ignored
//
// Optional build macro AXIL_REG_SLVERR_EN: when defined, out-of-range
// accesses and writes to the ID word answer SLVERR; otherwise every
// response is OKAY.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   s_axi_aw*/w*/b*              AXI4-Lite write channels
//   s_axi_ar*/r*                 AXI4-Lite read channels
//   reg_out [NREG*32-1:0]        register k at bits [32k+31:32k]
//   wr_pulse [NREG-1:0]          one-cycle pulse per committed register write
// -----------------------------------------------------------------------------
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int          NREG     = 8,
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [2:0]          s_axi_awprot,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,

  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [2:0]          s_axi_arprot,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,

  output logic [NREG*32-1:0]  reg_out,
  output logic [NREG-1:0]     wr_pulse
);

  localparam int IDX_W  = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int WIDX_W = ADDR_W - 2;
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(NREG);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]       r_regs [NREG];
  logic [NREG-1:0]   r_wr_pulse;

  wr_state_t         r_wr_state;
  logic              r_awready;
  logic              r_wready;
  logic              r_aw_held;
  logic              r_w_held;
  logic [WIDX_W-1:0] r_aw_idx;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_bvalid;
  logic [1:0]        r_bresp;

  rd_state_t         r_rd_state;
  logic              r_arready;
  logic              r_rvalid;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_commit;
  logic [WIDX_W-1:0] w_aw_idx_eff;
  logic [31:0]       w_wdata_eff;
  logic [3:0]        w_wstrb_eff;
  logic              w_wr_in_range;
  logic [WIDX_W-1:0] w_wr_off;
  logic [IDX_W-1:0]  w_wr_sel;
  logic [31:0]       w_merged;
  logic [1:0]        w_bresp_next;

  assign w_aw_hs = s_axi_awvalid && r_awready;
  assign w_w_hs  = s_axi_wvalid  && r_wready;

  // The commit is taken on the edge that completes the second of AW/W, so the
  // half arriving on that edge is used straight from the bus.
  assign w_aw_idx_eff = r_aw_held ? r_aw_idx : s_axi_awaddr[ADDR_W-1:2];
  assign w_wdata_eff  = r_w_held  ? r_wdata  : s_axi_wdata;
  assign w_wstrb_eff  = r_w_held  ? r_wstrb  : s_axi_wstrb;

  assign w_commit = (r_wr_state == WR_ACCEPT) &&
                    (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  assign w_wr_in_range = (w_aw_idx_eff != '0) && (w_aw_idx_eff <= LAST_IDX);
  assign w_wr_off      = w_aw_idx_eff - WIDX_W'(1);
  assign w_wr_sel      = w_wr_off[IDX_W-1:0];

  axil_strb_merge u_strb_merge (
    .i_old    (r_regs[w_wr_sel]),
    .i_new    (w_wdata_eff),
    .i_strb   (w_wstrb_eff),
    .o_merged (w_merged)
  );

`ifdef AXIL_REG_SLVERR_EN
  // ID word (index 0) and out-of-range indices are both outside 1..NREG.
  assign w_bresp_next = resp_code(!w_wr_in_range);
`else
  assign w_bresp_next = RESP_OKAY;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= WR_ACCEPT;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      case (r_wr_state)
        WR_ACCEPT: begin
          if (w_commit) begin
            r_wr_state <= WR_COMMIT;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_bresp    <= w_bresp_next;
          end else begin
            // Each half is captured on its own; ready rises again only for a
            // side that is not yet holding a beat (also covers reset exit).
            if (w_aw_hs) begin
              r_aw_held <= 1'b1;
              r_aw_idx  <= s_axi_awaddr[ADDR_W-1:2];
              r_awready <= 1'b0;
            end else if (!r_aw_held) begin
              r_awready <= 1'b1;
            end
            if (w_w_hs) begin
              r_w_held  <= 1'b1;
              r_wdata   <= s_axi_wdata;
              r_wstrb   <= s_axi_wstrb;
              r_wready  <= 1'b0;
            end else if (!r_w_held) begin
              r_wready  <= 1'b1;
            end
          end
        end
        WR_COMMIT: begin
          r_wr_state <= WR_RESP;
          r_bvalid   <= 1'b1;
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            r_wr_state <= WR_ACCEPT;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
          end
        end
        default: begin
          r_wr_state <= WR_ACCEPT;
        end
      endcase
    end
  end

  // Register bank: new value and wr_pulse appear together in the cycle after
  // the completing handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        r_regs[k] <= '0;
      end
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit && w_wr_in_range) begin
        r_regs[w_wr_sel]     <= w_merged;
        r_wr_pulse[w_wr_sel] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic              w_ar_hs;
  logic [WIDX_W-1:0] w_ar_idx;
  logic [WIDX_W-1:0] w_rd_off;
  logic [IDX_W-1:0]  w_rd_sel;
  logic              w_rd_in_range;
  logic [31:0]       w_rd_value;
  logic [1:0]        w_rresp_next;

  assign w_ar_hs       = s_axi_arvalid && r_arready;
  assign w_ar_idx      = s_axi_araddr[ADDR_W-1:2];
  assign w_rd_off      = w_ar_idx - WIDX_W'(1);
  assign w_rd_sel      = w_rd_off[IDX_W-1:0];
  assign w_rd_in_range = (w_ar_idx != '0) && (w_ar_idx <= LAST_IDX);

  // Sampled from the flops before any same-edge write lands, so a read
  // racing a commit to the same register sees the old value.
  always_comb begin
    w_rd_value = '0;
    if (w_ar_idx == '0) begin
      w_rd_value = ID_VALUE;
    end else if (w_rd_in_range) begin
      w_rd_value = r_regs[w_rd_sel];
    end
  end

`ifdef AXIL_REG_SLVERR_EN
  assign w_rresp_next = resp_code(w_ar_idx > LAST_IDX);
`else
  assign w_rresp_next = RESP_OKAY;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_rd_state <= RD_RESP;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rdata    <= w_rd_value;
            r_rresp    <= w_rresp_next;
          end else begin
            r_arready  <= 1'b1;
          end
        end
        RD_RESP: begin
          if (s_axi_rready) begin
            r_rd_state <= RD_IDLE;
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
          end
        end
        default: begin
          r_rd_state <= RD_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign wr_pulse      = r_wr_pulse;

  for (genvar k = 0; k < NREG; k++) begin : g_reg_out
    assign reg_out[32*k +: 32] = r_regs[k];
  end

  // Protection bits and byte offset carry no meaning for this register bank.
  logic w_unused;
  assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                      s_axi_araddr[1:0], w_wr_off, w_rd_off};

endmodule

// File: tb/tb_axil_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_axil_reg_slave
// Directed and lightly randomised bench for axil_reg_slave (NREG=8,
// ADDR_W=16). Read data and write responses are predicted from a bench-side
// register model and queued when the request is driven; they are popped and
// compared when the DUT presents R or B. Honours AXIL_REG_SLVERR_EN for the
// expected error responses.
// -----------------------------------------------------------------------------
module tb_axil_reg_slave;

  localparam int NREG   = 8;
  localparam int ADDR_W = 16;

`ifdef AXIL_REG_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  logic                clk;
  logic                rst;
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic [2:0]          s_axi_awprot;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [31:0]         s_axi_wdata;
  logic [3:0]          s_axi_wstrb;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic [2:0]          s_axi_arprot;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [31:0]         s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rvalid;
  logic                s_axi_rready;
  logic [NREG*32-1:0]  reg_out;
  logic [NREG-1:0]     wr_pulse;

  int checks = 0;
  int errors = 0;

  logic [NREG*32-1:0]  model_flat;
  logic [33:0]         exp_q[$];     // {rresp, rdata}
  logic [1:0]          exp_b_q[$];   // bresp

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  axil_reg_slave #(
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .reg_out       (reg_out),
    .wr_pulse      (wr_pulse)
  );

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_resp(input logic [ADDR_W-1:0] addr, input bit is_wr);
    int idx;
    idx = int'(addr[ADDR_W-1:2]);
    if (idx > NREG) return ERR_RESP;
    if (is_wr && idx == 0) return ERR_RESP;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] addr);
    int idx;
    idx = int'(addr[ADDR_W-1:2]);
    if (idx == 0) return 32'hD1C1_0001;
    if (idx > NREG) return 32'h0;
    return model_flat[32*(idx-1) +: 32];
  endfunction

  task automatic model_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [NREG-1:0] pulse);
    int idx;
    idx   = int'(addr[ADDR_W-1:2]);
    pulse = '0;
    if (idx >= 1 && idx <= NREG) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_flat[32*(idx-1) + 8*b +: 8] = data[8*b +: 8];
      end
      pulse[idx-1] = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: single read, checks latency and pops the scoreboard
  // ---------------------------------------------------------------------------
  task automatic axi_read(input logic [ADDR_W-1:0] addr);
    logic [33:0] e;
    int n;
    exp_q.push_back({exp_resp(addr, 1'b0), model_read(addr)});
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin
      tick();
      n++;
    end
    check("ar_hs_bound", 256'(n < 50), 256'(1));
    tick();                          // AR handshake edge
    s_axi_arvalid = 1'b0;
    check("rvalid_latency", 256'(s_axi_rvalid), 256'(1));
    check("arready_low_in_resp", 256'(s_axi_arready), 256'(0));
    e = exp_q.pop_front();
    check("rdata", 256'(s_axi_rdata), 256'(e[31:0]));
    check("rresp", 256'(s_axi_rresp), 256'(e[33:32]));
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check("rvalid_clear", 256'(s_axi_rvalid), 256'(0));
    check("arready_back", 256'(s_axi_arready), 256'(1));
  endtask

  // ---------------------------------------------------------------------------
  // Driver: single write. w_lead > 0 presents W that many cycles before AW,
  // w_lead < 0 presents AW first. bready is held low for b_wait cycles.
  // ---------------------------------------------------------------------------
  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_wait);
    logic [NREG-1:0] pulse;
    logic [1:0]      eb;
    bit              aw_done, w_done, aw_fire, w_fire;
    int              n, aw_start, w_start;
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    exp_b_q.push_back(exp_resp(addr, 1'b1));
    aw_done = 1'b0;
    w_done  = 1'b0;
    n = 0;
    while (!(aw_done && w_done) && n < 100) begin
      if (!aw_done && n >= aw_start) begin
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
      end
      if (!w_done && n >= w_start) begin
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wvalid = 1'b1;
      end
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid  && s_axi_wready;
      tick();
      n++;
      if (aw_fire) begin
        s_axi_awvalid = 1'b0;
        aw_done = 1'b1;
      end
      if (w_fire) begin
        s_axi_wvalid = 1'b0;
        w_done = 1'b1;
      end
      if (aw_done != w_done) begin
        check("half_held_no_pulse", 256'(wr_pulse), 256'(0));
        check("half_held_no_bvalid", 256'(s_axi_bvalid), 256'(0));
        if (aw_done) check("awready_low_after_aw", 256'(s_axi_awready), 256'(0));
        else         check("wready_low_after_w", 256'(s_axi_wready), 256'(0));
      end
    end
    check("wr_hs_bound", 256'(n < 100), 256'(1));
    model_write(addr, data, strb, pulse);
    check("wr_pulse_commit", 256'(wr_pulse), 256'(pulse));
    check("reg_out_commit", 256'(reg_out), 256'(model_flat));
    check("bvalid_not_yet", 256'(s_axi_bvalid), 256'(0));
    tick();
    check("wr_pulse_single", 256'(wr_pulse), 256'(0));
    check("bvalid_latency", 256'(s_axi_bvalid), 256'(1));
    eb = exp_b_q.pop_front();
    for (int i = 0; i < b_wait; i++) begin
      check("bresp_hold", 256'(s_axi_bresp), 256'(eb));
      check("readies_low_in_resp", 256'({s_axi_awready, s_axi_wready}), 256'(2'b00));
      tick();
      check("bvalid_hold", 256'(s_axi_bvalid), 256'(1));
      check("no_extra_pulse", 256'(wr_pulse), 256'(0));
    end
    check("bresp", 256'(s_axi_bresp), 256'(eb));
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("bvalid_clear", 256'(s_axi_bvalid), 256'(0));
    check("readies_after_b", 256'({s_axi_awready, s_axi_wready}), 256'(2'b11));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [NREG-1:0] pulse;
    logic [33:0]     e;
    logic [1:0]      eb;
    logic [ADDR_W-1:0] ra;

    rst           = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awprot  = 3'b000;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arprot  = 3'b000;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    model_flat    = '0;

    // Reset asserted between clock edges, checked before any edge arrives.
    #3 rst = 1'b1;
    #1;
    check("rst_awready", 256'(s_axi_awready), 256'(0));
    check("rst_wready", 256'(s_axi_wready), 256'(0));
    check("rst_arready", 256'(s_axi_arready), 256'(0));
    check("rst_bvalid", 256'(s_axi_bvalid), 256'(0));
    check("rst_rvalid", 256'(s_axi_rvalid), 256'(0));
    check("rst_resps", 256'({s_axi_bresp, s_axi_rresp}), 256'(4'b0000));
    check("rst_rdata", 256'(s_axi_rdata), 256'(0));
    check("rst_reg_out", 256'(reg_out), 256'(0));
    check("rst_wr_pulse", 256'(wr_pulse), 256'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("readies_before_edge", 256'({s_axi_awready, s_axi_wready, s_axi_arready}), 256'(3'b000));
    tick();
    check("readies_after_edge", 256'({s_axi_awready, s_axi_wready, s_axi_arready}), 256'(3'b111));

    // ID word.
    axi_read(16'h0000);

    // Byte-lane write to register 0, then read back.
    axi_write(16'h0004, 32'hAAAA_AAAA, 4'b0010, 0, 0);
    check("byte_lane_reg0", 256'(reg_out[31:0]), 256'(32'h0000_AA00));
    axi_read(16'h0004);

    // W leading AW, then AW leading W, each with a stalled B channel.
    axi_write(16'h0008, 32'h1234_5678, 4'hF, 3, 5);
    axi_write(16'h0010, 32'hCAFE_F00D, 4'b1001, -3, 5);
    axi_read(16'h0008);
    axi_read(16'h0010);

    // Last in-range register, out-of-range word, ID word write, zero strobes.
    axi_write(16'h0020, 32'h7777_0001, 4'hF, 0, 1);
    axi_read(16'h0020);
    axi_write(16'h0024, 32'hFFFF_FFFF, 4'hF, 1, 0);
    axi_read(16'h0024);
    axi_write(16'h0000, 32'h0BAD_0BAD, 4'hF, 0, 0);
    axi_read(16'h0000);
    axi_write(16'h0008, 32'hFFFF_FFFF, 4'h0, 0, 0);
    axi_read(16'h000B);

    // Read and write to register 2 completing on the same edge.
    axi_write(16'h000C, 32'h0000_0001, 4'hF, 0, 0);
    check("conc_readies", 256'({s_axi_awready, s_axi_wready, s_axi_arready}), 256'(3'b111));
    exp_q.push_back({exp_resp(16'h000C, 1'b0), model_read(16'h000C)});
    exp_b_q.push_back(exp_resp(16'h000C, 1'b1));
    s_axi_araddr  = 16'h000C;
    s_axi_arvalid = 1'b1;
    s_axi_awaddr  = 16'h000C;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = 32'h0000_0005;
    s_axi_wstrb   = 4'hF;
    s_axi_wvalid  = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    model_write(16'h000C, 32'h0000_0005, 4'hF, pulse);
    check("conc_rvalid", 256'(s_axi_rvalid), 256'(1));
    e = exp_q.pop_front();
    check("conc_rdata_old", 256'(s_axi_rdata), 256'(e[31:0]));
    check("conc_rresp", 256'(s_axi_rresp), 256'(e[33:32]));
    check("conc_wr_pulse", 256'(wr_pulse), 256'(pulse));
    check("conc_reg_out", 256'(reg_out), 256'(model_flat));
    s_axi_rready = 1'b1;
    s_axi_bready = 1'b1;
    tick();
    check("conc_rvalid_clear", 256'(s_axi_rvalid), 256'(0));
    check("conc_bvalid", 256'(s_axi_bvalid), 256'(1));
    eb = exp_b_q.pop_front();
    check("conc_bresp", 256'(s_axi_bresp), 256'(eb));
    tick();
    s_axi_rready = 1'b0;
    s_axi_bready = 1'b0;
    check("conc_bvalid_clear", 256'(s_axi_bvalid), 256'(0));
    axi_read(16'h000C);

    // Randomised mix, including out-of-range indices and ignored addr[1:0].
    for (int it = 0; it < 12; it++) begin
      axi_write(ADDR_W'(($urandom_range(0, 10) << 2) | $urandom_range(0, 3)), $urandom,
                4'($urandom_range(0, 15)), int'($urandom_range(0, 4)) - 2,
                int'($urandom_range(0, 2)));
      ra = ADDR_W'(($urandom_range(0, 10) << 2) | $urandom_range(0, 3));
      axi_read(ra);
    end

    // Reset with only AW held: that AW must be dropped, nothing committed.
    s_axi_awaddr  = 16'h0008;
    s_axi_awvalid = 1'b1;
    check("mid_awready", 256'(s_axi_awready), 256'(1));
    tick();
    s_axi_awvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_flat = '0;
    check("mid_rst_reg_out", 256'(reg_out), 256'(0));
    check("mid_rst_awready", 256'(s_axi_awready), 256'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    axi_write(16'h0010, 32'h0BAD_F00D, 4'hF, 3, 0);
    check("mid_rst_reg0_untouched", 256'(reg_out[31:0]), 256'(0));
    axi_read(16'h0010);

    check("queues_drained", 256'(exp_q.size() + exp_b_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net: stop a hung run with a visible failure.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
